// File: rtl/oscope_pkg.sv
// -----------------------------------------------------------------------------
// oscope_pkg
// Shared definitions for the oscilloscope Pi link blocks.
//   pi_op_t       : opcodes carried in the upper byte of a Pi->FPGA frame
//   rx_state_t    : receiver FSM states
//   PI_FRAME_BITS : number of serial bits in one command frame
//   op_is_known() : true for opcodes the receiver acts on
// -----------------------------------------------------------------------------
package oscope_pkg;

  localparam int PI_FRAME_BITS = 16;

  typedef enum logic [7:0] {
    OP_NOP   = 8'h00,
    OP_TRIG  = 8'h01,
    OP_DECIM = 8'h02,
    OP_ARM   = 8'h03,
    OP_DONE  = 8'h04
  } pi_op_t;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_SHIFT  = 2'd1,
    RX_DECODE = 2'd2
  } rx_state_t;

  // Opcodes above OP_DONE are reserved and reported as frame errors.
  function automatic logic op_is_known(input logic [7:0] op);
    return (op <= OP_DONE);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Brings one asynchronous input into the clk domain and reports its level and
// single-cycle rise/fall pulses. The level output is taken from the same flop
// that the edge detector compares against, so a rise pulse and the level of a
// companion signal passed through another instance line up on the same cycle.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous, active-high; clears the edge pulses only
//   i_async   in  asynchronous input
//   o_level   out synchronized level (aligned with o_rise/o_fall)
//   o_rise    out 1-cycle pulse on a 0->1 transition
//   o_fall    out 1-cycle pulse on a 1->0 transition
// -----------------------------------------------------------------------------
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;

  // NOTE: the synchronizer chain is deliberately not reset. It keeps tracking
  // the pin during reset, so a line already high when reset releases does not
  // look like a fresh rising edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    r_prev <= r_sync[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <=  r_sync[SYNC_STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[SYNC_STAGES-1] &  r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/pi_cmd_rx.sv
// -----------------------------------------------------------------------------
// pi_cmd_rx
// Pi->FPGA serial command receiver. Oversamples pi_sel/pi_clk/pi_cmd on
// osc_clk, assembles MSB-first frames ([15:8] opcode, [7:0] payload) and
// turns them into scope control registers and single-cycle strobes.
// Ports:
//   osc_clk     in   system clock (Pi bit rate <= osc_clk/8)
//   reset       in   synchronous, active-high
//   pi_sel      in   async frame select, high while a frame is in progress
//   pi_clk      in   async serial clock, data taken on its rising edge
//   pi_cmd      in   async serial data
//   trig_level  out  trigger threshold register
//   decim       out  decimation register (keep 1 of decim+1 samples)
//   arm         out  1-cycle strobe: re-arm capture
//   done        out  1-cycle strobe: Pi finished reading the buffer
//   cmd_valid   out  1-cycle strobe: legal frame decoded
//   frame_err   out  1-cycle strobe: bad length or unknown opcode
// All outputs are registered. Latency from pi_sel falling at the pins to the
// strobe/register update is SYNC_STAGES+3 osc_clk cycles.
// -----------------------------------------------------------------------------
module pi_cmd_rx
  import oscope_pkg::*;
#(
  parameter int         SYNC_STAGES   = 2,
  parameter int         FRAME_BITS    = PI_FRAME_BITS,
  parameter logic [7:0] TRIG_DEFAULT  = 8'h80,
  parameter logic [7:0] DECIM_DEFAULT = 8'h00
) (
  input  logic       osc_clk,
  input  logic       reset,
  input  logic       pi_sel,
  input  logic       pi_clk,
  input  logic       pi_cmd,
  output logic [7:0] trig_level,
  output logic [7:0] decim,
  output logic       arm,
  output logic       done,
  output logic       cmd_valid,
  output logic       frame_err
);

  // Counter saturates one past a full frame so over-long frames stay distinct.
  localparam int            CW       = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic w_sel_lvl, w_sel_rise, w_sel_fall;
  logic w_clk_rise;
  logic w_cmd_lvl;
  logic w_clk_lvl_unused, w_clk_fall_unused;
  logic w_cmd_rise_unused, w_cmd_fall_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sel (
    .clk     (osc_clk),
    .reset   (reset),
    .i_async (pi_sel),
    .o_level (w_sel_lvl),
    .o_rise  (w_sel_rise),
    .o_fall  (w_sel_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk     (osc_clk),
    .reset   (reset),
    .i_async (pi_clk),
    .o_level (w_clk_lvl_unused),
    .o_rise  (w_clk_rise),
    .o_fall  (w_clk_fall_unused)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cmd (
    .clk     (osc_clk),
    .reset   (reset),
    .i_async (pi_cmd),
    .o_level (w_cmd_lvl),
    .o_rise  (w_cmd_rise_unused),
    .o_fall  (w_cmd_fall_unused)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  rx_state_t             r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [CW-1:0]         r_count;
  // Set once pi_sel has been seen low after reset; a frame that was already
  // open when reset released is ignored until its select drops.
  logic                  r_sel_low_seen;

  rx_state_t             w_state_nxt;
  logic [FRAME_BITS-1:0] w_shift_nxt;
  logic [CW-1:0]         w_count_nxt;
  logic [7:0]            w_trig_nxt;
  logic [7:0]            w_decim_nxt;
  logic                  w_arm_nxt;
  logic                  w_done_nxt;
  logic                  w_valid_nxt;
  logic                  w_err_nxt;

  logic [7:0] w_opcode;
  logic [7:0] w_payload;

  assign w_opcode  = r_shift[FRAME_BITS-1 -: 8];
  assign w_payload = r_shift[7:0];

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_count_nxt = r_count;
    w_trig_nxt  = trig_level;
    w_decim_nxt = decim;
    w_arm_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;

    unique case (r_state)
      RX_IDLE: begin
        if (w_sel_rise && r_sel_low_seen) begin
          w_state_nxt = RX_SHIFT;
          w_shift_nxt = '0;
          w_count_nxt = '0;
        end
      end

      RX_SHIFT: begin
        // End of frame wins over a coincident pi_clk rise: that bit is dropped.
        if (w_sel_fall) begin
          w_state_nxt = RX_DECODE;
        end else if (w_clk_rise) begin
          w_shift_nxt = {r_shift[FRAME_BITS-2:0], w_cmd_lvl};
          if (r_count != CNT_SAT) begin
            w_count_nxt = r_count + 1'b1;
          end
        end
      end

      RX_DECODE: begin
        w_state_nxt = RX_IDLE;
        if ((r_count == CNT_FULL) && op_is_known(w_opcode)) begin
          w_valid_nxt = 1'b1;
          case (w_opcode)
            OP_TRIG:  w_trig_nxt  = w_payload;
            OP_DECIM: w_decim_nxt = w_payload;
            OP_ARM:   w_arm_nxt   = 1'b1;
            OP_DONE:  w_done_nxt  = 1'b1;
            default:  ;  // OP_NOP: acknowledge only
          endcase
        end else begin
          w_err_nxt = 1'b1;
        end
      end

      default: w_state_nxt = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      r_shift        <= '0;
      r_count        <= '0;
      r_sel_low_seen <= 1'b0;
      trig_level     <= TRIG_DEFAULT;
      decim          <= DECIM_DEFAULT;
      arm            <= 1'b0;
      done           <= 1'b0;
      cmd_valid      <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      r_shift        <= w_shift_nxt;
      r_count        <= w_count_nxt;
      r_sel_low_seen <= r_sel_low_seen | ~w_sel_lvl;
      trig_level     <= w_trig_nxt;
      decim          <= w_decim_nxt;
      arm            <= w_arm_nxt;
      done           <= w_done_nxt;
      cmd_valid      <= w_valid_nxt;
      frame_err      <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_pi_cmd_rx.sv
// -----------------------------------------------------------------------------
// tb_pi_cmd_rx
// Self-checking bench for pi_cmd_rx: a directed table of frames, hand-written
// reset sequences, and random frames scored against a frame-level model.
// -----------------------------------------------------------------------------
module tb_pi_cmd_rx;
  import oscope_pkg::*;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 3;
  localparam int OBS  = 14;

  logic       osc_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       pi_sel  = 1'b0;
  logic       pi_clk  = 1'b0;
  logic       pi_cmd  = 1'b0;
  logic [7:0] trig_level;
  logic [7:0] decim;
  logic       arm;
  logic       done;
  logic       cmd_valid;
  logic       frame_err;

  pi_cmd_rx #(.SYNC_STAGES(SYNC)) dut (
    .osc_clk    (osc_clk),
    .reset      (reset),
    .pi_sel     (pi_sel),
    .pi_clk     (pi_clk),
    .pi_cmd     (pi_cmd),
    .trig_level (trig_level),
    .decim      (decim),
    .arm        (arm),
    .done       (done),
    .cmd_valid  (cmd_valid),
    .frame_err  (frame_err)
  );

  always #5 osc_clk = ~osc_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level reference state.
  logic [7:0] m_trig  = 8'h80;
  logic [7:0] m_decim = 8'h00;

  typedef struct {
    logic [16:0] bits;
    int          nbits;
    int          half;
    bit          race;
    bit          e_valid;
    bit          e_err;
    bit          e_arm;
    bit          e_done;
    logic [7:0]  e_trig;
    logic [7:0]  e_decim;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n clock cycles and settle just after the edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge osc_clk);
    #1;
  endtask

  task automatic start_frame(input int half);
    pi_clk = 1'b0;
    pi_sel = 1'b1;
    cycles(half);
  endtask

  task automatic send_bits(input logic [16:0] bits, input int nbits, input int half);
    for (int i = nbits - 1; i >= 0; i--) begin
      pi_clk = 1'b0;
      pi_cmd = bits[i];
      cycles(half);
      pi_clk = 1'b1;
      cycles(half);
    end
  endtask

  // With race set, an extra pi_clk rise lands on the same instant as sel fall.
  task automatic end_frame(input int half, input bit race);
    pi_clk = 1'b0;
    if (race) pi_cmd = 1'($urandom_range(0, 1));
    cycles(half);
    if (race) pi_clk = 1'b1;
    pi_sel = 1'b0;
  endtask

  // Watch the outputs for OBS cycles following a sel fall.
  task automatic observe(output int n_v, output int n_e, output int n_a,
                         output int n_d, output int n_both, output int first);
    n_v = 0; n_e = 0; n_a = 0; n_d = 0; n_both = 0; first = -1;
    for (int k = 1; k <= OBS; k++) begin
      @(posedge osc_clk);
      #1;
      if ((cmd_valid || frame_err) && first < 0) first = k;
      n_v    += int'(cmd_valid);
      n_e    += int'(frame_err);
      n_a    += int'(arm);
      n_d    += int'(done);
      n_both += int'(cmd_valid && frame_err);
    end
  endtask

  task automatic run_frame(input string tag, input logic [16:0] bits, input int nbits,
                           input int half, input bit race,
                           input bit e_v, input bit e_e, input bit e_a, input bit e_d,
                           input logic [7:0] e_trig, input logic [7:0] e_decim);
    int n_v, n_e, n_a, n_d, n_both, first;
    start_frame(half);
    send_bits(bits, nbits, half);
    end_frame(half, race);
    observe(n_v, n_e, n_a, n_d, n_both, first);
    check({tag, ".cmd_valid_cycles"}, n_v, int'(e_v));
    check({tag, ".frame_err_cycles"}, n_e, int'(e_e));
    check({tag, ".arm_cycles"},       n_a, int'(e_a));
    check({tag, ".done_cycles"},      n_d, int'(e_d));
    check({tag, ".valid_and_err"},    n_both, 0);
    check({tag, ".latency"},          first, LAT);
    check({tag, ".trig_level"},       trig_level, e_trig);
    check({tag, ".decim"},            decim, e_decim);
  endtask

  // Frame-level reference: only the bit count and the opcode byte matter.
  task automatic model_frame(input logic [16:0] bits, input int nbits,
                             output bit v, output bit e, output bit a, output bit d);
    logic [7:0] op = bits[15:8];
    logic [7:0] pl = bits[7:0];
    v = 0; e = 0; a = 0; d = 0;
    if (nbits != 16 || op > 8'd4) begin
      e = 1;
    end else begin
      v = 1;
      if (op == 8'd1) m_trig  = pl;
      if (op == 8'd2) m_decim = pl;
      if (op == 8'd3) a = 1;
      if (op == 8'd4) d = 1;
    end
  endtask

  initial begin
    int any_strobe;

    //          bits       n   half race  v  e  a  d  trig   decim
    vecs[0]  = '{17'h0013C, 16, 5, 1'b0, 1, 0, 0, 0, 8'h3C, 8'h00};
    vecs[1]  = '{17'h00300, 16, 5, 1'b0, 1, 0, 1, 0, 8'h3C, 8'h00};
    vecs[2]  = '{17'h004FF, 16, 5, 1'b0, 1, 0, 0, 1, 8'h3C, 8'h00};
    vecs[3]  = '{17'h00155, 15, 5, 1'b0, 0, 1, 0, 0, 8'h3C, 8'h00};  // first 15 bits of 0x02AB
    vecs[4]  = '{17'h004CD, 17, 5, 1'b0, 0, 1, 0, 0, 8'h3C, 8'h00};  // 0x0266 plus one extra bit
    vecs[5]  = '{17'h00712, 16, 5, 1'b0, 0, 1, 0, 0, 8'h3C, 8'h00};
    vecs[6]  = '{17'h00000,  0, 5, 1'b0, 0, 1, 0, 0, 8'h3C, 8'h00};
    vecs[7]  = '{17'h00000, 16, 5, 1'b0, 1, 0, 0, 0, 8'h3C, 8'h00};
    vecs[8]  = '{17'h002A5, 16, 5, 1'b1, 1, 0, 0, 0, 8'h3C, 8'hA5};
    vecs[9]  = '{17'h00111, 16, 4, 1'b1, 1, 0, 0, 0, 8'h11, 8'hA5};
    vecs[10] = '{17'h00277, 16, 4, 1'b0, 1, 0, 0, 0, 8'h11, 8'h77};
    vecs[11] = '{17'h00599, 16, 5, 1'b0, 0, 1, 0, 0, 8'h11, 8'h77};

    // Reset values with pins idle.
    reset = 1'b1;
    cycles(4);
    reset = 1'b0;
    any_strobe = 0;
    for (int k = 0; k < 20; k++) begin
      cycles(1);
      any_strobe += int'(arm || done || cmd_valid || frame_err);
    end
    check("reset.strobes", any_strobe, 0);
    check("reset.trig_level", trig_level, 8'h80);
    check("reset.decim", decim, 8'h00);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].bits, vecs[i].nbits, vecs[i].half,
                vecs[i].race, vecs[i].e_valid, vecs[i].e_err, vecs[i].e_arm,
                vecs[i].e_done, vecs[i].e_trig, vecs[i].e_decim);
      m_trig  = vecs[i].e_trig;
      m_decim = vecs[i].e_decim;
    end

    // Reset after 8 bits of 0x0255, sel held high through release, then dropped.
    begin
      int n_v, n_e, n_a, n_d, n_both, first;
      start_frame(5);
      send_bits(17'h00002, 8, 5);
      pi_clk = 1'b0;
      reset  = 1'b1;
      cycles(4);
      reset  = 1'b0;
      m_trig  = 8'h80;
      m_decim = 8'h00;
      cycles(10);
      pi_sel = 1'b0;
      observe(n_v, n_e, n_a, n_d, n_both, first);
      check("midreset.strobes", n_v + n_e + n_a + n_d, 0);
      check("midreset.decim", decim, 8'h00);
      check("midreset.trig_level", trig_level, 8'h80);
      run_frame("midreset.next", 17'h00255, 16, 5, 1'b0, 1, 0, 0, 0, 8'h80, 8'h55);
      m_decim = 8'h55;
    end

    // Random frames against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] f;
      logic [16:0] bits;
      int          nbits;
      int          sel;
      bit          v, e, a, d;
      f       = 16'($urandom);
      f[15:8] = 8'($urandom_range(0, 7));
      sel     = int'($urandom_range(0, 9));
      case (sel)
        0:       begin nbits = 15; bits = {2'b00, f[15:1]}; end
        1:       begin nbits = 17; bits = {f, 1'($urandom_range(0, 1))}; end
        2:       begin nbits = 0;  bits = '0; end
        default: begin nbits = 16; bits = {1'b0, f}; end
      endcase
      model_frame(bits, nbits, v, e, a, d);
      run_frame($sformatf("rnd%0d", i), bits, nbits, int'($urandom_range(4, 6)),
                1'($urandom_range(0, 1)), v, e, a, d, m_trig, m_decim);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
